// File: rtl/hack_cpu_core_pkg.sv
// Shared constants for the Hack CPU core: widths and instruction-field bit positions.
package hack_cpu_core_pkg;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 15;

    // C-instruction layout: 111a cccccc ddd jjj
    localparam int CI_BIT = 15;
    localparam int A_BIT  = 12;
    localparam int C_MSB  = 11;
    localparam int DEST_A = 5;
    localparam int DEST_D = 4;
    localparam int DEST_M = 3;
    localparam int J_LT   = 2;
    localparam int J_EQ   = 1;
    localparam int J_GT   = 0;
endpackage

// File: rtl/hack_cpu_core_if.sv
// ROM/RAM-side bus of the Hack CPU core.
interface hack_cpu_core_if;
    import hack_cpu_core_pkg::*;

    logic [DATA_W-1:0] instruction;
    logic              instr_valid;
    logic [DATA_W-1:0] inM;
    logic [DATA_W-1:0] outM;
    logic              writeM;
    logic [ADDR_W-1:0] addressM;
    logic [ADDR_W-1:0] pc;

    // CPU side
    modport master (
        input  instruction, instr_valid, inM,
        output outM, writeM, addressM, pc
    );

    // Memory / environment side
    modport slave (
        output instruction, instr_valid, inM,
        input  outM, writeM, addressM, pc
    );
endinterface

// File: rtl/hack_alu.sv
// Existing Hack ALU: six control bits select among the 18 Hack functions.
module hack_alu (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        zx,
    input  logic        nx,
    input  logic        zy,
    input  logic        ny,
    input  logic        f,
    input  logic        no,
    output logic [15:0] out,
    output logic        zr,
    output logic        ng
);
    logic [15:0] x1, x2, y1, y2, r;

    // Operand conditioning, function select and output negation
    always_comb begin
        x1  = zx ? 16'h0000 : x;
        x2  = nx ? ~x1 : x1;
        y1  = zy ? 16'h0000 : y;
        y2  = ny ? ~y1 : y1;
        r   = f ? (x2 + y2) : (x2 & y2);
        out = no ? ~r : r;
        zr  = (out == 16'h0000);
        ng  = out[15];
    end
endmodule

// File: rtl/hack_cpu_core_pc.sv
// Program counter: hold has priority over load, load over increment.
module hack_pc #(
    parameter int ADDR_W   = 15,
    parameter int RESET_PC = 0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              load_i,
    input  logic              inc_i,
    input  logic              hold_i,
    input  logic [ADDR_W-1:0] d_i,
    output logic [ADDR_W-1:0] q_o
);
    logic [ADDR_W-1:0] pc_q, pc_d;

    // Next-count selection; increment wraps naturally at the top of the range
    always_comb begin
        pc_d = pc_q;
        if (hold_i)     pc_d = pc_q;
        else if (load_i) pc_d = d_i;
        else if (inc_i)  pc_d = pc_q + 1'b1;
    end

    // Counter register with asynchronous clear to RESET_PC
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) pc_q <= ADDR_W'(RESET_PC);
        else          pc_q <= pc_d;
    end

    assign q_o = pc_q;
endmodule

// File: rtl/hack_cpu_core.sv
// Hack CPU control/register stage: decodes, holds A/D/PC, drives the ALU, resolves jumps.
module hack_cpu_core
    import hack_cpu_core_pkg::*;
#(
    parameter int RESET_PC = 0
) (
    input  logic               clock,
    input  logic               reset_n,
    hack_cpu_core_if.master    bus
);
    logic [DATA_W-1:0] a_q, a_d, d_q, d_d;
    logic [DATA_W-1:0] ins, alu_y, alu_out;
    logic              alu_zr, alu_ng;
    logic              is_c, exec, jump;

    assign ins   = bus.instruction;
    assign is_c  = ins[CI_BIT];
    assign exec  = bus.instr_valid;
    assign alu_y = ins[A_BIT] ? bus.inM : a_q;

    hack_alu u_alu (
        .x  (d_q),
        .y  (alu_y),
        .zx (ins[C_MSB]),
        .nx (ins[C_MSB-1]),
        .zy (ins[C_MSB-2]),
        .ny (ins[C_MSB-3]),
        .f  (ins[C_MSB-4]),
        .no (ins[C_MSB-5]),
        .out(alu_out),
        .zr (alu_zr),
        .ng (alu_ng)
    );

    // Jump condition from the ALU flags; A-instructions never jump
    always_comb begin
        jump = is_c & ((ins[J_LT] & alu_ng) |
                       (ins[J_EQ] & alu_zr) |
                       (ins[J_GT] & ~alu_ng & ~alu_zr));
    end

    // Jump target is the A value before this edge's update
    hack_pc #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) u_pc (
        .clock  (clock),
        .reset_n(reset_n),
        .load_i (exec & jump),
        .inc_i  (exec & ~jump),
        .hold_i (~exec),
        .d_i    (a_q[ADDR_W-1:0]),
        .q_o    (bus.pc)
    );

    // Next A/D: A-instruction loads A with the literal, C-instruction writes selected dests
    always_comb begin
        a_d = a_q;
        d_d = d_q;
        if (exec) begin
            if (!is_c) begin
                a_d = {1'b0, ins[DATA_W-2:0]};
            end else begin
                if (ins[DEST_A]) a_d = alu_out;
                if (ins[DEST_D]) d_d = alu_out;
            end
        end
    end

    // A and D registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_q <= '0;
            d_q <= '0;
        end else begin
            a_q <= a_d;
            d_q <= d_d;
        end
    end

    // Memory side: write address is the registered (old) A, write gated by reset and stall
    assign bus.outM     = alu_out;
    assign bus.writeM   = reset_n & exec & is_c & ins[DEST_M];
    assign bus.addressM = a_q[ADDR_W-1:0];
endmodule

// File: doc/hack_cpu_core.md
Name: hack_cpu_core

Overview:
Sequential control and register stage that feeds the existing Hack ALU. It sits directly upstream of the ALU and consumes the ALU's output and flags.
- Decodes each 16-bit Hack instruction.
- Holds the A register, the D register and the program counter.
- Drives the ALU operands (x=D, y=A or inM) and its six control bits.
- Writes ALU results back to A, D or memory, and evaluates jumps using the zr/ng flags.

Parameters:
DATA_W, 16, data path width (fixed at 16 for the Hack ISA)
ADDR_W, 15, width of the PC and addressM
RESET_PC, 0, PC value loaded on reset

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
instruction  input  16  current instruction word at ROM[pc]
instr_valid  input  1  1 = execute instruction this cycle; 0 = stall (hold all state)
inM  input  16  data read from RAM[addressM]
outM  output  16  ALU result (combinational), data to write to RAM
writeM  output  1  RAM write enable (combinational)
addressM  output  15  RAM address = A[14:0] (registered)
pc  output  15  address of next instruction (registered)

Behaviour:
- One clock; reset is asynchronous and active-low. While reset_n=0: A=0, D=0, pc=RESET_PC, writeM forced 0. addressM is therefore 0. outM is the ALU output for the current instruction with A=D=0.
- A-instruction (bit15=0): on the clock edge, A <= {1'b0, instruction[14:0]} and pc <= pc+1. writeM=0.
- C-instruction (bit15=1), format 111a cccccc ddd jjj. Bits 14:13 are ignored.
- Operand select: x=D; y = inM if a (bit12) = 1, else A.
- ALU control mapping: zx=bit11, nx=bit10, zy=bit9, ny=bit8, f=bit7, no=bit6.
- Destinations: bit5 → A <= outM; bit4 → D <= outM; bit3 → writeM=1 this cycle.
- Jump: taken = (bit2 & ng) | (bit1 & zr) | (bit0 & ~ng & ~zr). If taken, pc <= A[14:0] using the pre-update A; otherwise pc <= pc+1.
- Single-cycle execution; no pipelining. All register updates occur on the same rising edge.
- Same-edge rules:
  - A-dest and jump in the same instruction: the jump target is the old A.
  - M-dest: the write address is the old A (addressM is registered).
  - A, D and M may all be written in the same instruction with the same outM.
- Stall: instr_valid=0 holds A, D and pc, and forces writeM=0.
- Arithmetic: 16-bit two's complement, performed by the ALU, wrapping without overflow detection. pc+1 wraps 0x7FFF → 0x0000.
- Mid-operation reset: asserting reset_n clears A, D and pc immediately, without waiting for a clock edge. The first instruction after release executes from RESET_PC.

Decomposition:
- Shared package: instruction-field bit positions (A_BIT=12, C_MSB=11, DEST_A=5, DEST_D=4, DEST_M=3, J_LT=2, J_EQ=1, J_GT=0) and DATA_W/ADDR_W constants.
- Reuse the existing ALU module unchanged as an instance.
- One new sub-module, hack_pc: 15-bit counter with async active-low reset and inputs load, inc, hold.

Test Plan:
1. Reset check: reset_n=0 mid-run with A=9, D=24, pc=5 → between clock edges A=D=0, pc=0, addressM=0, writeM=0. Release reset → first fetch from pc=0.
2. Load and add:
   - 0x0009 → A=9, pc=1.
   - 0xEC10 (D=A) → D=9, pc=2.
   - 0x000F, then 0xE090 (D=D+A) → D=24, pc=4.
3. Memory write: 0x0064 (@100), then 0xE308 (M=D) → during the M=D cycle writeM=1, addressM=100, outM=24. D unchanged.
4. Read-modify-write with A update: A=100, inM=41, instruction 0xFDE8 (AM=M+1) → outM=42, writeM=1, addressM=100 this cycle. Next cycle A=42, addressM=42.
5. Jumps:
   - A=20, D=24, 0xE301 (D;JGT) → pc=20.
   - D=0, 0xE301 → pc=pc+1.
   - D=0, 0xE302 (D;JEQ) → pc=20.
   - 0xEA87 (0;JMP) → pc=A.
6. Stall and wrap:
   - instr_valid=0 with 0xEC10 → A, D, pc unchanged; writeM=0.
   - 0x7FFF then 0xEA87 → pc=0x7FFF. Next A-instruction → pc=0x0000.
